// File: rtl/mips_multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcode/funct
// constants, ALU codes, the FSM state type and the per-state control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    // fetchwr marks FETCH: irwrite and the fetch PC update are both gated by
    // mem_ready outside the register, so they track the handshake same-cycle.
    typedef struct packed {
        logic       memwrite;
        logic       iord;
        logic       fetchwr;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    // Moore control word for a state; anything not set here stays 0.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetchwr = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE: begin
                c.alusrcb = 2'b11;
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: begin
                c.iord = 1'b1;
            end
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB: begin
                c.regwrite = 1'b1;
            end
            JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_controller_aludec.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field to the
// ALU control code, flagging functs the ALU does not implement.
module mips_aludec
    import mips_pkg::*;
#(
    parameter int FUNCTW = 6,
    parameter int ALUCW  = 3
) (
    input  logic [1:0]        aluop,
    input  logic [FUNCTW-1:0] funct,
    output logic [ALUCW-1:0]  alucontrol,
    output logic              bad_funct
);

    // Unknown functs fall back to add so the instruction still completes.
    always_comb begin
        alucontrol = ALU_ADD;
        bad_funct  = 1'b0;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: bad_funct  = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: a Moore FSM sequencing each instruction over
// 3-5 cycles with a memory-ready wait handshake and illegal-opcode flagging.
// Optional macro MIPS_BNE_EN adds bne (branch when not zero).
module mips_multicycle_controller
    import mips_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int FUNCTW = 6,
    parameter int ALUCW  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    op,
    input  logic [FUNCTW-1:0] funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              memwrite,
    output logic              iord,
    output logic              irwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic              pcen,
    output logic [ALUCW-1:0]  alucontrol,
    output logic              illegal,
    output logic [3:0]        state_o
);

    state_t state;
    state_t nextstate;
    ctrl_t  ctl;
    logic   isstore;
    logic   legalop;
    logic   branchcond;
    logic   badfunct;
    logic   fetchgo;

`ifdef MIPS_BNE_EN
    logic   isbne;
`endif

    // Opcodes this controller can sequence; anything else is flagged in DECODE.
    always_comb begin
        legalop = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: legalop = 1'b1;
`ifdef MIPS_BNE_EN
            OP_BNE: legalop = 1'b1;
`endif
            default: legalop = 1'b0;
        endcase
    end

    // Next-state logic; op is only consulted in DECODE, lw/sw choice uses the tag.
    always_comb begin
        nextstate = FETCH;
        case (state)
            FETCH:  nextstate = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nextstate = MEMADR;
                    OP_RTYPE:     nextstate = EXECUTE;
                    OP_BEQ:       nextstate = BRANCH;
`ifdef MIPS_BNE_EN
                    OP_BNE:       nextstate = BRANCH;
`endif
                    OP_ADDI:      nextstate = ADDIEXEC;
                    OP_J:         nextstate = JUMP;
                    default:      nextstate = FETCH;
                endcase
            end
            MEMADR:   nextstate = isstore ? MEMWR : MEMRD;
            MEMRD:    nextstate = mem_ready ? MEMWB : MEMRD;
            MEMWB:    nextstate = FETCH;
            MEMWR:    nextstate = mem_ready ? FETCH : MEMWR;
            EXECUTE:  nextstate = ALUWB;
            ALUWB:    nextstate = FETCH;
            BRANCH:   nextstate = FETCH;
            ADDIEXEC: nextstate = ADDIWB;
            ADDIWB:   nextstate = FETCH;
            JUMP:     nextstate = FETCH;
            default:  nextstate = FETCH;
        endcase
    end

    // State register with the control word registered alongside it, plus the
    // instruction tags captured in DECODE so later states never look at op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            ctl     <= state_ctrl(FETCH);
            isstore <= 1'b0;
`ifdef MIPS_BNE_EN
            isbne   <= 1'b0;
`endif
        end else begin
            state <= nextstate;
            ctl   <= state_ctrl(nextstate);
            if (state == DECODE) begin
                isstore <= (op == OP_SW);
`ifdef MIPS_BNE_EN
                isbne   <= (op == OP_BNE);
`endif
            end
        end
    end

`ifdef MIPS_BNE_EN
    assign branchcond = isbne ? ~zero : zero;
`else
    assign branchcond = zero;
`endif

    mips_aludec #(
        .FUNCTW(FUNCTW),
        .ALUCW (ALUCW)
    ) u_aludec (
        .aluop     (ctl.aluop),
        .funct     (funct),
        .alucontrol(alucontrol),
        .bad_funct (badfunct)
    );

    assign fetchgo  = ctl.fetchwr & mem_ready;
    assign memwrite = ctl.memwrite;
    assign iord     = ctl.iord;
    assign irwrite  = fetchgo;
    assign regdst   = ctl.regdst;
    assign memtoreg = ctl.memtoreg;
    assign regwrite = ctl.regwrite;
    assign alusrca  = ctl.alusrca;
    assign alusrcb  = ctl.alusrcb;
    assign pcsrc    = ctl.pcsrc;
    assign pcen     = fetchgo | ctl.pcwrite | (ctl.branch & branchcond);
    assign illegal  = ((state == DECODE) & ~legalop) | badfunct;
    assign state_o  = state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for mips_multicycle_controller. A driver walks each
// instruction through the state sequence its class implies and queues the
// expected per-cycle outputs; a monitor pops and compares each cycle.
// Expectations for bne follow the MIPS_BNE_EN macro.
module tb_mips_multicycle_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] aluc;
        logic       illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen, illegal;
    logic [2:0] alucontrol;
    logic [3:0] state_o;

    exp_t expQ[$];
    int   nCompares = 0;
    int   nMiscompares = 0;

    mips_multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .memwrite  (memwrite),
        .iord      (iord),
        .irwrite   (irwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .pcen      (pcen),
        .alucontrol(alucontrol),
        .illegal   (illegal),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Opcodes the controller should accept.
    function automatic logic opLegal(logic [5:0] o);
        case (o)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MIPS_BNE_EN
            6'b000101: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // R-type funct to ALU code; bit 3 flags an unsupported funct.
    function automatic logic [3:0] functAlu(logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b1010;
        endcase
    endfunction

    // Expected outputs for one cycle of a given step of an instruction.
    function automatic exp_t expectFor(int step, logic rdy, logic z, logic [5:0] iop, logic [5:0] ifn);
        exp_t e;
        logic [3:0] fa;
        e      = '0;
        e.st   = 4'(step);
        e.aluc = 3'b010;
        fa     = functAlu(ifn);
        case (step)
            0:  begin e.alusrcb = 2'b01; e.irwrite = rdy; e.pcen = rdy; end
            1:  begin e.alusrcb = 2'b11; e.illegal = ~opLegal(iop); end
            2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            6:  begin e.alusrca = 1'b1; e.aluc = fa[2:0]; e.illegal = fa[3]; end
            7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            8:  begin
                    e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
                    e.pcen = (iop == 6'b000101) ? ~z : z;
                end
            9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            10: e.regwrite = 1'b1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Compare one queued expectation against what the DUT shows now.
    task automatic checkOutput(input exp_t e);
        exp_t a;
        a = {state_o, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, pcen, alucontrol, illegal};
        nCompares++;
        if (a.st !== e.st) begin
            nMiscompares++;
            $display("[TB] FAIL state at %0t: got %0d want %0d", $time, a.st, e.st);
        end
        nCompares++;
        if (a[15:0] !== e[15:0]) begin
            nMiscompares++;
            $display("[TB] FAIL controls in state %0d at %0t: got %b want %b (mw iord irw rdst m2r rw asa asb pcs pcen aluc ill)",
                     e.st, $time, a[15:0], e[15:0]);
        end
    endtask

    // Monitor: pops one expectation per cycle, away from the active edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // Drive one instruction to completion (or until an injected reset).
    task automatic applyStimulus(input logic [5:0] iop, input logic [5:0] ifn, input int waitPct,
                                 input int rdWaits, input int resetAt, input int zeroForce);
        int steps[$];
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        int st;
        logic rdy, z, rst, waitStep;
        case (iop)
            6'b100011: steps = '{0, 1, 2, 3, 4};
            6'b101011: steps = '{0, 1, 2, 5};
            6'b000000: steps = '{0, 1, 6, 7};
            6'b000100: steps = '{0, 1, 8};
`ifdef MIPS_BNE_EN
            6'b000101: steps = '{0, 1, 8};
`endif
            6'b001000: steps = '{0, 1, 9, 10};
            6'b000010: steps = '{0, 1, 11};
            default:   steps = '{0, 1};
        endcase
        while (idx < steps.size()) begin
            st = steps[idx];
            waitStep = (st == 0) || (st == 3) || (st == 5);
            @(posedge clk);
            #1;
            if (waitStep) begin
                if (st == 3 && rdWaits > 0) begin
                    rdy = 1'b0;
                    rdWaits--;
                end else if (stall >= 6) rdy = 1'b1;
                else rdy = ($urandom_range(99) >= waitPct);
            end else begin
                rdy = 1'($urandom_range(1));
            end
            stall = rdy ? 0 : stall + 1;
            z   = (zeroForce < 0) ? 1'($urandom_range(1)) : zeroForce[0];
            rst = (cyc == resetAt);
            mem_ready = rdy;
            zero      = z;
            reset     = rst;
            op        = (st == 1) ? iop : 6'($urandom);
            funct     = (st == 6) ? ifn : 6'($urandom);
            expQ.push_back(expectFor(st, rdy, z, iop, ifn));
            cyc++;
            if (rst) break;
            if (!(waitStep && !rdy)) idx++;
        end
    endtask

    // Keeps the run bounded regardless of DUT behaviour.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] fl [5];
        logic [5:0] rop, rfn;
        int kind, rat;
        fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100;
        fl[3] = 6'b100101; fl[4] = 6'b101010;

        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = 6'b0; funct = 6'b0;
        // Two reset cycles; outputs show FETCH with mem_ready high.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            expQ.push_back(expectFor(0, 1'b1, 1'b0, 6'b0, 6'b0));
        end

        applyStimulus(6'b001000, 6'b000000, 0, 0, -1, -1);
        applyStimulus(6'b000000, 6'b100010, 0, 0, -1, -1);
        applyStimulus(6'b000000, 6'b101010, 0, 0, -1, -1);
        applyStimulus(6'b000000, 6'b111000, 0, 0, -1, -1);
        applyStimulus(6'b100011, 6'b000000, 0, 2, -1, -1);
        applyStimulus(6'b000100, 6'b000000, 0, 0, -1, 0);
        applyStimulus(6'b000100, 6'b000000, 0, 0, -1, 1);
        applyStimulus(6'b000101, 6'b000000, 0, 0, -1, 0);
        applyStimulus(6'b000010, 6'b000000, 0, 0, -1, -1);
        applyStimulus(6'b111111, 6'b000000, 0, 0, -1, -1);
        applyStimulus(6'b101011, 6'b000000, 0, 0, 3, -1);
        applyStimulus(6'b101011, 6'b000000, 50, 0, -1, -1);

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(9);
            rfn  = ($urandom_range(3) == 0) ? 6'($urandom) : fl[$urandom_range(4)];
            case (kind)
                0:       rop = 6'b100011;
                1:       rop = 6'b101011;
                3:       rop = 6'b000100;
                4:       rop = 6'b000101;
                5:       rop = 6'b001000;
                6:       rop = 6'b000010;
                7:       rop = 6'($urandom);
                default: rop = 6'b000000;
            endcase
            rat = ($urandom_range(99) < 4) ? $urandom_range(5) : -1;
            applyStimulus(rop, rfn, 30, 0, rat, -1);
        end

        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        nCompares++;
        if (expQ.size() != 0) begin
            nMiscompares++;
            $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
        $finish;
    end

endmodule
